// File: rtl/generator.sv
// generator
//   Stream source that emits an incrementing, wrapping value sequence on a
//   valid/ready output channel. It produces one beat per clock at full
//   throughput. Back-pressure holds the pending beat, and a beat is never
//   lost or repeated.
//
// Ports
//   aclk      in   clock; all state updates on its rising edge
//   aresetn   in   asynchronous reset, ACTIVE-HIGH despite the name
//   enable    in   level-sensitive permission to produce new beats
//   ready     in   downstream acceptance
//   data_out  out  current beat payload (registered)
//   valid     out  data_out holds a beat (registered)
module generator #(
    parameter int     DATA_WIDTH = 8,
    parameter int     INIT_VALUE = 0,
    parameter int     STEP       = 1,
    parameter longint MAX_VALUE  = (longint'(1) << DATA_WIDTH) - 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  enable,
    input  logic                  ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid
);

    localparam logic [DATA_WIDTH-1:0] C_INIT = DATA_WIDTH'(INIT_VALUE);
    localparam logic [DATA_WIDTH:0]   C_STEP = (DATA_WIDTH+1)'(STEP);
    localparam logic [DATA_WIDTH:0]   C_MAX  = (DATA_WIDTH+1)'(MAX_VALUE);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_next;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;

    // The sum is one bit wider than the data, so next+STEP cannot overflow.
    // Comparing against MAX therefore gives the same result as the rule
    // next > MAX-STEP, without the underflow that MAX-STEP could cause.
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_adv;
    logic                  w_load;

    assign w_sum  = {1'b0, r_next} + C_STEP;
    assign w_adv  = (w_sum > C_MAX) ? C_INIT : w_sum[DATA_WIDTH-1:0];
    // A new beat may be loaded when the slot is empty or is being emptied now.
    assign w_load = enable && (!r_valid || ready);

    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            r_state <= IDLE;
            r_next  <= C_INIT;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_data  <= r_next;
                        r_valid <= 1'b1;
                        r_next  <= w_adv;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    // With ready low, everything holds. The beat stays valid
                    // even if enable drops.
                    if (ready) begin
                        if (w_load) begin
                            r_data <= r_next;
                            r_next <= w_adv;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_out = r_data;
    assign valid    = r_valid;

endmodule

// File: tb/tb_generator.sv
// tb_generator
//   This bench drives three generator configurations from one shared stimulus.
//   A transaction-level model follows each configuration. The model works out
//   the k-th beat value with modular arithmetic, and it keeps a queue of the
//   beats that were accepted.
module tb_generator;

    localparam int N = 3;
    localparam int P_INIT [N] = '{0, 10, 5};
    localparam int P_STEP [N] = '{1, 1, 7};
    localparam int P_MAX  [N] = '{255, 12, 200};

    logic       aclk = 1'b0;
    logic       aresetn;
    logic       enable;
    logic       ready;
    logic [7:0] dout [N];
    logic       vld  [N];

    int checks = 0;
    int errors = 0;

    // Model state for each instance.
    logic       m_valid [N];
    logic [7:0] m_data  [N];
    int         m_cnt   [N];
    int         acc     [N][$];

    always #5 aclk = ~aclk;

    generator #(.DATA_WIDTH(8), .INIT_VALUE(0), .STEP(1), .MAX_VALUE(255)) u_g0 (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .ready(ready),
        .data_out(dout[0]), .valid(vld[0]));
    generator #(.DATA_WIDTH(8), .INIT_VALUE(10), .STEP(1), .MAX_VALUE(12)) u_g1 (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .ready(ready),
        .data_out(dout[1]), .valid(vld[1]));
    generator #(.DATA_WIDTH(8), .INIT_VALUE(5), .STEP(7), .MAX_VALUE(200)) u_g2 (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .ready(ready),
        .data_out(dout[2]), .valid(vld[2]));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Value of the k-th beat since reset. The sequence is INIT, INIT+STEP, ...
    // It stops at the last value that is <= MAX, then starts again at INIT.
    function automatic int beat(input int i, input int k);
        int n;
        n = (P_MAX[i] - P_INIT[i]) / P_STEP[i] + 1;
        return P_INIT[i] + (k % n) * P_STEP[i];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = 8'd0;
            m_cnt[i]   = 0;
            acc[i].delete();
        end
    endfunction

    task automatic compare_all(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s valid[%0d]", tag, i), int'(vld[i]), int'(m_valid[i]));
            check($sformatf("%s data[%0d]", tag, i), int'(dout[i]), int'(m_data[i]));
        end
    endtask

    // Apply the inputs for one clock, let the edge happen, then update the
    // model and compare the outputs 1ns after the edge.
    task automatic step(input logic en, input logic rd);
        enable = en;
        ready  = rd;
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && rd)
                acc[i].push_back(int'(m_data[i]));
            if (en && (!m_valid[i] || rd)) begin
                m_data[i]  = 8'(beat(i, m_cnt[i]));
                m_cnt[i]++;
                m_valid[i] = 1'b1;
            end else if (m_valid[i] && rd) begin
                m_valid[i] = 1'b0;
            end
        end
        compare_all("step");
    endtask

    // Assert reset between clock edges and check that it acts immediately.
    task automatic async_reset();
        #2;
        aresetn = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        @(posedge aclk);
        #1;
        compare_all("rst_hold");
        aresetn = 1'b0;
    endtask

    initial begin
        aresetn = 1'b1;
        enable  = 1'b0;
        ready   = 1'b0;
        model_reset();
        #3;
        compare_all("reset");
        @(posedge aclk);
        #1;
        aresetn = 1'b0;

        // Run at full throughput, then pause and resume.
        for (int c = 0; c < 5; c++) step(1'b1, 1'b1);
        for (int c = 0; c < 5; c++) step(1'b0, 1'b0);
        for (int c = 0; c < 5; c++) step(1'b1, 1'b1);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b1);
        check("resume_seq", (acc[0].size() >= 10) ? acc[0][9] : -1, 9);

        // Back-pressure with enable held high.
        step(1'b1, 1'b0);
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0);
        for (int c = 0; c < 3; c++) step(1'b1, 1'b1);

        // Drop enable during a stall. The pending beat must still be delivered.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b1);

        // Reset in the middle of the stream, then restart from INIT_VALUE.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        async_reset();
        step(1'b1, 1'b1);
        check("first_after_rst", int'(dout[0]), 0);

        // Long continuous run: 258 beats accepted on instance 0.
        async_reset();
        for (int c = 0; c < 259; c++) step(1'b1, 1'b1);
        check("wrap_len", acc[0].size(), 258);
        if (acc[0].size() == 258) begin
            check("wrap_254", acc[0][254], 254);
            check("wrap_255", acc[0][255], 255);
            check("wrap_0",   acc[0][256], 0);
            check("wrap_1",   acc[0][257], 1);
        end
        if (acc[1].size() >= 5) begin
            check("small_a", acc[1][2], 12);
            check("small_b", acc[1][3], 10);
            check("small_c", acc[1][4], 11);
        end
        check("step7_wrap", (acc[2].size() >= 29) ? acc[2][28] : -1, 5);

        // Random traffic, with an occasional asynchronous reset.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0)
                async_reset();
            else
                step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/generator.md
Name: generator

Overview:
- Parameterised data-source block that emits an incrementing, wrapping value sequence on a valid/ready (AXI-Stream-style) output channel.
- Used as a stimulus/traffic source feeding downstream stream consumers; production is gated by a level-sensitive enable.
- One beat per clock at full throughput; back-pressure is honoured without data loss.

Parameters:
- DATA_WIDTH, 8, width of data_out.
- INIT_VALUE, 0, first value emitted after reset and the value the sequence wraps back to.
- STEP, 1, increment added between consecutive beats; must be >= 1.
- MAX_VALUE, 2**DATA_WIDTH-1, largest value the sequence may emit before wrapping; must be >= INIT_VALUE.

Ports:
- aclk  input  1  single clock; all state updates on its rising edge.
- aresetn  input  1  reset; asynchronous and active-high (asserted when 1) despite the name.
- enable  input  1  level-sensitive permission to produce new beats.
- ready  input  1  downstream acceptance.
- data_out  output  DATA_WIDTH  current beat payload, registered.
- valid  output  1  data_out holds a beat, registered.

Behaviour:
- Internal state:
  - next_val register (DATA_WIDTH), holding the value to emit next.
  - Output register pair (data_out, valid).
  - Two-state FSM: IDLE (valid=0), HOLD (valid=1).
- Reset (aresetn=1, asynchronous):
  - valid=0, data_out=0, next_val=INIT_VALUE, FSM=IDLE.
  - Takes effect immediately, mid-beat included; a pending unaccepted beat is discarded.
- Advance rule: next_val <= (next_val > MAX_VALUE-STEP) ? INIT_VALUE : next_val+STEP. Computed without overflow at DATA_WIDTH.
- IDLE:
  - enable=1 at a rising edge: data_out<=next_val, valid<=1, next_val advances, go to HOLD.
  - enable=0: stay in IDLE; data_out keeps its last value.
- HOLD, ready=1 (transfer completes this edge):
  - If enable=1, load the next beat at the same edge (back-to-back, 1 beat/cycle, valid stays 1).
  - Otherwise valid<=0 and go to IDLE.
- HOLD, ready=0:
  - data_out and valid held stable. valid is never withdrawn before acceptance, even if enable drops.
  - next_val is not advanced.
- Latency: first valid beat appears one clock after enable is sampled high.
- Sequence continuity:
  - Deasserting enable pauses the sequence; it does not restart it.
  - Resuming continues from next_val. Only reset returns to INIT_VALUE.
- Wrap example: DATA_WIDTH=8, STEP=1, MAX_VALUE=255 gives ...,254,255,0,1,...
- Each accepted beat is emitted exactly once. No duplicates, no gaps.
- ready is ignored while valid=0.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then enable=1, ready=1 held for 5 cycles -> valid rises 1 cycle after enable; accepted data 0,1,2,3,4, one per clock.
- Pause/resume: after accepting 0..4, enable=0, ready=0 for 5 cycles, then enable=1, ready=1 for 5 cycles -> valid drops; resumed beats are 5,6,7,8,9 (no restart).
- Back-pressure: enable=1, ready=0 for 4 cycles while a beat of value 3 is pending, then ready=1 -> data_out stays 3 with valid=1 throughout the stall; next accepted beat is 4.
- Enable drop under stall: valid=1 with data_out=7 and ready=0, drop enable, then ready=1 one cycle later -> 7 is accepted, then valid=0 and no further beats.
- Wrap: STEP=1, MAX_VALUE=255, run continuously for 258 beats -> accepted sequence ends 254,255,0,1. Second run with INIT_VALUE=10, MAX_VALUE=12, STEP=1 -> 10,11,12,10,11.
- Asynchronous reset mid-stream: assert aresetn=1 between clock edges while valid=1 -> valid=0 and data_out=0 immediately. After release with enable=1, the first beat is INIT_VALUE.
